// File: rtl/seq_compare_unit_pkg.sv
// Shared encodings and helpers for the multi-cycle sequential comparator.
package seq_compare_unit_pkg;

  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_NE  = 3'b001,
    OP_LT  = 3'b010,
    OP_LTU = 3'b011,
    OP_GE  = 3'b100,
    OP_GEU = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_LT) || (op == OP_GE);
  endfunction

  // Reserved encodings deliberately yield 0 while the flags stay meaningful.
  function automatic logic op_result(input logic [2:0] op, input logic ne, input logic lt);
    case (op)
      OP_EQ:         return ~ne;
      OP_NE:         return ne;
      OP_LT, OP_LTU: return lt;
      OP_GE, OP_GEU: return ~lt;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_compare_unit_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             neq,
  output logic             ltu
);

  assign neq = |(a ^ b);
  assign ltu = (a < b);

endmodule

// File: rtl/seq_compare_unit.sv
// Multi-cycle comparator: scans operands CHUNK bits per cycle, MSB first,
// stopping at the first differing chunk.
module seq_compare_unit
  import seq_compare_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             ready,
  output logic             done,
  output logic             result,
  output logic             ne_flag,
  output logic             lt_flag
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             result_q, result_d;
  logic             ne_q, ne_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             chunk_neq, chunk_ltu;

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (index_q == IDX_W'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a   (chunk_a),
    .b   (chunk_b),
    .neq (chunk_neq),
    .ltu (chunk_ltu)
  );

  // Flipping the sign bit of both operands turns signed order into unsigned order.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    index_d  = index_q;
    result_d = result_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = data_a ^ (is_signed_op(op) ? SIGN_MASK : '0);
          b_d     = data_b ^ (is_signed_op(op) ? SIGN_MASK : '0);
          index_d = LAST_IDX;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (chunk_neq) begin
          ne_d     = 1'b1;
          lt_d     = chunk_ltu;
          result_d = op_result(op_q, 1'b1, chunk_ltu);
          state_d  = ST_DONE;
        end else if (index_q == '0) begin
          ne_d     = 1'b0;
          lt_d     = 1'b0;
          result_d = op_result(op_q, 1'b0, 1'b0);
          state_d  = ST_DONE;
        end else begin
          index_d = index_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      index_q  <= '0;
      result_q <= 1'b0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      index_q  <= index_d;
      result_q <= result_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign result  = result_q;
  assign ne_flag = ne_q;
  assign lt_flag = lt_q;

endmodule

// File: tb/tb_seq_compare_unit.sv
// Directed bench for seq_compare_unit: 32/8 main instance plus 16/16 and 8/1 sweeps.
module tb_seq_compare_unit;
  import seq_compare_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic        start0 = 1'b0;
  logic [2:0]  op0 = 3'b000;
  logic [31:0] a0 = '0, b0 = '0;
  logic        ready0, done0, result0, ne0, lt0;

  logic        start_s = 1'b0;
  logic [2:0]  op_s = 3'b000;
  logic [15:0] a_s = '0, b_s = '0;
  logic        ready1, done1, result1, ne1, lt1;
  logic        ready2, done2, result2, ne2, lt2;

  int num_checks = 0;
  int num_fail   = 0;

  always #5 clock = ~clock;

  seq_compare_unit #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clock(clock), .reset(reset), .start(start0), .op(op0), .data_a(a0), .data_b(b0),
    .ready(ready0), .done(done0), .result(result0), .ne_flag(ne0), .lt_flag(lt0)
  );

  seq_compare_unit #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clock(clock), .reset(reset), .start(start_s), .op(op_s), .data_a(a_s), .data_b(b_s),
    .ready(ready1), .done(done1), .result(result1), .ne_flag(ne1), .lt_flag(lt1)
  );

  seq_compare_unit #(.WIDTH(8), .CHUNK(1)) u_dut8 (
    .clock(clock), .reset(reset), .start(start_s), .op(op_s), .data_a(a_s[7:0]), .data_b(b_s[7:0]),
    .ready(ready2), .done(done2), .result(result2), .ne_flag(ne2), .lt_flag(lt2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Independent model: true signed/unsigned compare plus MSB-first latency rule.
  function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input int w, input int chunk,
                                   output logic res, output logic ne, output logic lt, output int lat);
    logic [31:0] m, am, bm, cm;
    longint sa, sb;
    int nchunk;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    cm = (chunk == 32) ? 32'hFFFF_FFFF : ((32'd1 << chunk) - 32'd1);
    am = a & m;
    bm = b & m;
    sa = longint'(am);
    sb = longint'(bm);
    if (op == 3'b010 || op == 3'b100) begin
      if (am[w-1]) sa -= (longint'(1) << w);
      if (bm[w-1]) sb -= (longint'(1) << w);
    end
    ne = (am != bm);
    lt = (sa < sb);
    case (op)
      3'b000: res = ~ne;
      3'b001: res = ne;
      3'b010, 3'b011: res = lt;
      3'b100, 3'b101: res = ~lt;
      default: res = 1'b0;
    endcase
    nchunk = w / chunk;
    lat = nchunk + 1;
    for (int k = 1; k <= nchunk; k++) begin
      if (((am >> ((nchunk - k) * chunk)) & cm) != ((bm >> ((nchunk - k) * chunk)) & cm)) begin
        lat = k + 1;
        break;
      end
    end
  endfunction

  task automatic waitReady0();
    int n = 0;
    @(negedge clock);
    while (!ready0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!ready0) checkOutput("ready0_timeout", 32'(ready0), 32'd1);
  endtask

  task automatic waitDone0(output int lat);
    lat = 1;
    while (!done0 && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (!done0) lat = -1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int lat);
    waitReady0();
    start0 = 1'b1;
    op0    = op;
    a0     = a;
    b0     = b;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    a0     = ~a;
    b0     = ~b;
    waitDone0(lat);
  endtask

  task automatic runCase(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic exp_res,
                         input logic exp_ne, input logic exp_lt);
    int lat;
    applyStimulus(op, a, b, lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_result"}, 32'(result0), 32'(exp_res));
    checkOutput({tag, "_ne"}, 32'(ne0), 32'(exp_ne));
    checkOutput({tag, "_lt"}, 32'(lt0), 32'(exp_lt));
  endtask

  task automatic runSweep(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int cyc, lat1, lat2, e_lat1, e_lat2, n;
    logic e_res1, e_ne1, e_lt1, e_res2, e_ne2, e_lt2;
    n = 0;
    @(negedge clock);
    while (!(ready1 && ready2) && n < 50) begin
      @(negedge clock);
      n++;
    end
    start_s = 1'b1;
    op_s    = op;
    a_s     = a;
    b_s     = b;
    @(posedge clock);
    #1;
    start_s = 1'b0;
    a_s     = ~a;
    b_s     = ~b;
    cyc  = 1;
    lat1 = -1;
    lat2 = -1;
    while (cyc < 50) begin
      if (done1 && lat1 < 0) lat1 = cyc;
      if (done2 && lat2 < 0) lat2 = cyc;
      if (lat1 >= 0 && lat2 >= 0) break;
      @(posedge clock);
      #1;
      cyc++;
    end
    refModel(op, 32'(a), 32'(b), 16, 16, e_res1, e_ne1, e_lt1, e_lat1);
    refModel(op, 32'(a), 32'(b), 8, 1, e_res2, e_ne2, e_lt2, e_lat2);
    checkOutput("w16_lat", 32'(lat1), 32'(e_lat1));
    checkOutput("w16_result", 32'(result1), 32'(e_res1));
    checkOutput("w16_ne", 32'(ne1), 32'(e_ne1));
    checkOutput("w16_lt", 32'(lt1), 32'(e_lt1));
    checkOutput("w8c1_lat", 32'(lat2), 32'(e_lat2));
    checkOutput("w8c1_result", 32'(result2), 32'(e_res2));
    checkOutput("w8c1_ne", 32'(ne2), 32'(e_ne2));
    checkOutput("w8c1_lt", 32'(lt2), 32'(e_lt2));
  endtask

  initial begin
    int lat;
    int pulses;
    logic [15:0] sw_a [4];
    logic [15:0] sw_b [4];
    sw_a = '{16'h8001, 16'h00A5, 16'h1234, 16'h0000};
    sw_b = '{16'h7FFF, 16'h00A5, 16'h12F4, 16'hFFFF};

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_ready", 32'(ready0), 32'd1);
    checkOutput("rst_done", 32'(done0), 32'd0);
    checkOutput("rst_result", 32'(result0), 32'd0);
    checkOutput("rst_ne", 32'(ne0), 32'd0);
    checkOutput("rst_lt", 32'(lt0), 32'd0);
    reset = 1'b1;

    runCase("eq_equal", OP_EQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, 1'b1, 1'b0, 1'b0);

    // Reset mid-SCAN: accept at edge 0, drop reset during cycle 2.
    waitReady0();
    start0 = 1'b1;
    op0    = OP_EQ;
    a0     = 32'h1234_5678;
    b0     = 32'h1234_5678;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    checkOutput("midrst_ready", 32'(ready0), 32'd1);
    checkOutput("midrst_result", 32'(result0), 32'd0);
    checkOutput("midrst_ne", 32'(ne0), 32'd0);
    checkOutput("midrst_lt", 32'(lt0), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done0) pulses++;
      @(posedge clock);
      #1;
    end
    checkOutput("midrst_no_done", 32'(pulses), 32'd0);

    runCase("ltu_early", OP_LTU, 32'h0100_0000, 32'h0200_0000, 2, 1'b1, 1'b1, 1'b1);
    runCase("lt_signed", OP_LT, 32'hFFFF_FFFF, 32'h0000_0001, 2, 1'b1, 1'b1, 1'b1);
    runCase("ltu_same", OP_LTU, 32'hFFFF_FFFF, 32'h0000_0001, 2, 1'b0, 1'b1, 1'b0);
    runCase("ge_lsb", OP_GE, 32'h0000_0005, 32'h0000_0004, 5, 1'b1, 1'b1, 1'b0);
    runCase("ge_negpos", OP_GE, 32'h8000_0000, 32'h7FFF_FFFF, 2, 1'b0, 1'b1, 1'b1);
    runCase("ne_equal", OP_NE, 32'hCAFE_0001, 32'hCAFE_0001, 5, 1'b0, 1'b0, 1'b0);
    runCase("ne_mid", OP_NE, 32'h00AB_0000, 32'h00AC_0000, 3, 1'b1, 1'b1, 1'b1);
    runCase("reserved", 3'b110, 32'h0000_1000, 32'h0000_2000, 4, 1'b0, 1'b1, 1'b1);

    // start held high through SCAN/DONE with different operands.
    waitReady0();
    start0 = 1'b1;
    op0    = OP_EQ;
    a0     = 32'h1122_3344;
    b0     = 32'h1122_3344;
    @(posedge clock);
    #1;
    op0 = OP_GEU;
    a0  = 32'h0000_0000;
    b0  = 32'hFFFF_FFFF;
    checkOutput("hold_busy", 32'(ready0), 32'd0);
    waitDone0(lat);
    checkOutput("hold_lat", 32'(lat), 32'd5);
    checkOutput("hold_result", 32'(result0), 32'd1);
    checkOutput("hold_ne", 32'(ne0), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("hold_ready_after", 32'(ready0), 32'd1);
    checkOutput("hold_done_clear", 32'(done0), 32'd0);
    @(posedge clock);
    #1;
    start0 = 1'b0;
    checkOutput("hold2_busy", 32'(ready0), 32'd0);
    checkOutput("hold2_result_kept", 32'(result0), 32'd1);
    waitDone0(lat);
    checkOutput("hold2_lat", 32'(lat), 32'd2);
    checkOutput("hold2_result", 32'(result0), 32'd0);
    checkOutput("hold2_ne", 32'(ne0), 32'd1);
    checkOutput("hold2_lt", 32'(lt0), 32'd1);

    for (int o = 0; o < 8; o++) begin
      for (int p = 0; p < 4; p++) begin
        runSweep(3'(o), sw_a[p], sw_b[p]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule
